// File: rtl/turn_scheduler.sv
// Turn sequencer for a Generals match. It rotates through the alive players and
// enforces a per-turn timeout. It also emits a growth tick per rotation and detects the end of the game.
module turn_scheduler #(
  parameter int MAX_PLAYER_CNT      = 7,
  parameter int LOG2_MAX_PLAYER_CNT = $clog2(MAX_PLAYER_CNT + 1),
  parameter int LOG2_MAX_ROUND      = 12,
  parameter int TIMER_WIDTH         = 32,
  parameter int TURN_CYCLES         = 1_000_000_000
) (
  input  logic                           clk_100M,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [MAX_PLAYER_CNT-1:0]      alive,
  input  logic                           move_done,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] current_player,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] next_player,
  output logic [LOG2_MAX_ROUND-1:0]      round,
  output logic [TIMER_WIDTH-1:0]         turn_timer,
  output logic                           turn_start,
  output logic                           turn_timeout,
  output logic                           round_end,
  output logic                           game_over,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] winner
);

  typedef logic [LOG2_MAX_PLAYER_CNT-1:0] player_t;
  typedef struct packed {
    logic    wrap;
    player_t idx;
  } step_t;
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GROW, S_OVER} state_t;

  localparam logic [TIMER_WIDTH-1:0]    TIMER_RELOAD = TIMER_WIDTH'(TURN_CYCLES - 1);
  localparam logic [LOG2_MAX_ROUND-1:0] ROUND_MAX    = '1;

  // Lowest alive player above p. If there is none, the result wraps to the lowest alive player.
  function automatic step_t nxt(input player_t p, input logic [MAX_PLAYER_CNT-1:0] a);
    step_t   s;
    player_t first;
    first  = '0;
    s.wrap = 1'b1;
    s.idx  = '0;
    for (int i = MAX_PLAYER_CNT; i >= 1; i--) begin
      if (a[i-1]) begin
        first = player_t'(i);
        if (i > int'(p)) begin
          s.idx  = player_t'(i);
          s.wrap = 1'b0;
        end
      end
    end
    if (s.wrap) s.idx = first;
    return s;
  endfunction

  state_t                   state, state_d;
  player_t                  current_player_d, next_player_d, winner_d, grow_next, grow_next_d;
  logic [LOG2_MAX_ROUND-1:0] round_d;
  logic [TIMER_WIDTH-1:0]   turn_timer_d;
  logic                     turn_start_d, round_end_d, game_over_d, grow_draw, grow_draw_d;

  logic    cur_alive, few_alive, turn_end, load, go_over;
  player_t first_alive, load_player, over_winner;
  step_t   cur_step;

  always_comb begin
    cur_alive = 1'b0;
    for (int i = 1; i <= MAX_PLAYER_CNT; i++) begin
      if (current_player == player_t'(i)) cur_alive = alive[i-1];
    end
  end

  assign few_alive    = $countones(alive) <= 1;
  assign first_alive  = nxt('0, alive).idx;
  assign cur_step     = nxt(current_player, alive);
  // Priority is move > elimination > timeout, so the pulse fires only when the timer alone ends the turn.
  assign turn_end     = move_done || !cur_alive || (turn_timer == '0);
  assign turn_timeout = (state == S_ACTIVE) && (turn_timer == '0) && !move_done && cur_alive;

  // NOTE: every variable assigned below receives a default first, so no path can infer a latch.
  always_comb begin
    state_d          = state;
    current_player_d = current_player;
    next_player_d    = next_player;
    round_d          = round;
    turn_timer_d     = turn_timer;
    turn_start_d     = 1'b0;
    round_end_d      = 1'b0;
    game_over_d      = game_over;
    winner_d         = winner;
    grow_next_d      = grow_next;
    grow_draw_d      = grow_draw;
    load             = 1'b0;
    load_player      = '0;
    go_over          = 1'b0;
    over_winner      = '0;

    unique case (state)
      S_IDLE, S_OVER: begin
        if (start) begin
          if (few_alive) begin
            go_over     = 1'b1;
            over_winner = first_alive;
          end else begin
            state_d     = S_ACTIVE;
            load        = 1'b1;
            load_player = first_alive;
            round_d     = LOG2_MAX_ROUND'(1);
            winner_d    = '0;
            game_over_d = 1'b0;
          end
        end
      end
      S_ACTIVE: begin
        if (!turn_end) begin
          turn_timer_d = turn_timer - TIMER_WIDTH'(1);
        end else if (few_alive) begin
          go_over     = 1'b1;
          over_winner = first_alive;
        end else if (cur_step.wrap) begin
          state_d     = S_GROW;
          round_end_d = 1'b1;
          grow_next_d = cur_step.idx;
          grow_draw_d = (round == ROUND_MAX);
          if (round != ROUND_MAX) round_d = round + LOG2_MAX_ROUND'(1);
        end else begin
          load        = 1'b1;
          load_player = cur_step.idx;
        end
      end
      S_GROW: begin
        if (grow_draw) begin
          go_over = 1'b1;
        end else begin
          state_d     = S_ACTIVE;
          load        = 1'b1;
          load_player = grow_next;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      current_player_d = load_player;
      next_player_d    = nxt(load_player, alive).idx;
      turn_timer_d     = TIMER_RELOAD;
      turn_start_d     = 1'b1;
    end
    if (go_over) begin
      state_d          = S_OVER;
      game_over_d      = 1'b1;
      winner_d         = over_winner;
      current_player_d = '0;
      next_player_d    = '0;
      turn_timer_d     = '0;
    end
  end

  // NOTE: state is written with non-blocking assignments only. Every register resets because all of them feed outputs.
  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      current_player <= '0;
      next_player    <= '0;
      round          <= '0;
      turn_timer     <= '0;
      turn_start     <= 1'b0;
      round_end      <= 1'b0;
      game_over      <= 1'b0;
      winner         <= '0;
      grow_next      <= '0;
      grow_draw      <= 1'b0;
    end else begin
      state          <= state_d;
      current_player <= current_player_d;
      next_player    <= next_player_d;
      round          <= round_d;
      turn_timer     <= turn_timer_d;
      turn_start     <= turn_start_d;
      round_end      <= round_end_d;
      game_over      <= game_over_d;
      winner         <= winner_d;
      grow_next      <= grow_next_d;
      grow_draw      <= grow_draw_d;
    end
  end

endmodule

// File: tb/tb_turn_scheduler.sv
// Scoreboard bench for turn_scheduler. A game-rule model predicts timed events, and a negedge monitor
// matches each DUT pulse against the next predicted event.
module tb_turn_scheduler;
  localparam int N    = 7;
  localparam int PW   = 3;
  localparam int RW   = 3;
  localparam int TW   = 32;
  localparam int T    = 20;
  localparam int RMAX = (1 << RW) - 1;

  logic          clk_100M = 1'b0;
  logic          reset_n  = 1'b0;
  logic          start    = 1'b0;
  logic          move_done = 1'b0;
  logic [N-1:0]  alive    = '0;
  logic [PW-1:0] current_player, next_player, winner;
  logic [RW-1:0] round;
  logic [TW-1:0] turn_timer;
  logic          turn_start, turn_timeout, round_end, game_over;

  turn_scheduler #(
    .MAX_PLAYER_CNT(N), .LOG2_MAX_PLAYER_CNT(PW), .LOG2_MAX_ROUND(RW),
    .TIMER_WIDTH(TW), .TURN_CYCLES(T)
  ) dut (
    .clk_100M(clk_100M), .reset_n(reset_n), .start(start), .alive(alive),
    .move_done(move_done), .current_player(current_player), .next_player(next_player),
    .round(round), .turn_timer(turn_timer), .turn_start(turn_start),
    .turn_timeout(turn_timeout), .round_end(round_end), .game_over(game_over),
    .winner(winner)
  );

  always #5 clk_100M = ~clk_100M;

  int cyc = 0;
  always @(posedge clk_100M) cyc <= cyc + 1;

  typedef enum {EV_START, EV_TIMEOUT, EV_ROUND, EV_OVER} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
    int       player;
    int       nxt;
    int       round;   // -1: not checked
    int       winner;
  } ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (game rules) ----------------
  typedef enum {M_IDLE, M_PLAY, M_GROW, M_OVER} mphase_t;
  mphase_t m_phase = M_IDLE;
  int m_cur, m_round, m_elapsed, m_pending;
  bit m_draw;

  function automatic int first_of(input logic [N-1:0] a);
    for (int i = 1; i <= N; i++) if (a[i-1]) return i;
    return 0;
  endfunction

  function automatic int after(input int p, input logic [N-1:0] a, output bit wrapped);
    wrapped = 1'b0;
    for (int i = p + 1; i <= N; i++) if (a[i-1]) return i;
    wrapped = 1'b1;
    return first_of(a);
  endfunction

  task automatic push(input ev_kind_t k, input int c, input int pl, input int nx, input int rd, input int wn);
    ev_t e;
    e.kind = k; e.cyc = c; e.player = pl; e.nxt = nx; e.round = rd; e.winner = wn;
    exp_q.push_back(e);
  endtask

  task automatic model_step(input bit st, input logic [N-1:0] a, input bit mv);
    bit w;
    int n, nn;
    bit cur_alive;
    case (m_phase)
      M_IDLE, M_OVER: if (st) begin
        if ($countones(a) <= 1) begin
          if (m_phase != M_OVER) push(EV_OVER, cyc + 1, 0, 0, 0, first_of(a));
          m_phase = M_OVER;
        end else begin
          m_phase = M_PLAY; m_cur = first_of(a); m_round = 1; m_elapsed = 0;
          nn = after(m_cur, a, w);
          push(EV_START, cyc + 1, m_cur, nn, 1, 0);
        end
      end
      M_PLAY: begin
        cur_alive = a[m_cur-1];
        if (mv || !cur_alive || m_elapsed == T - 1) begin
          if (!mv && cur_alive) push(EV_TIMEOUT, cyc, m_cur, 0, 0, 0);
          if ($countones(a) <= 1) begin
            push(EV_OVER, cyc + 1, 0, 0, 0, first_of(a));
            m_phase = M_OVER;
          end else begin
            n = after(m_cur, a, w);
            if (w) begin
              m_draw = (m_round == RMAX);
              if (!m_draw) m_round++;
              push(EV_ROUND, cyc + 1, 0, 0, m_draw ? -1 : m_round, 0);
              m_pending = n;
              m_phase = M_GROW;
            end else begin
              m_cur = n; m_elapsed = 0;
              nn = after(n, a, w);
              push(EV_START, cyc + 1, n, nn, m_round, 0);
            end
          end
        end else begin
          m_elapsed++;
        end
      end
      M_GROW: begin
        if (m_draw) begin
          push(EV_OVER, cyc + 1, 0, 0, 0, 0);
          m_phase = M_OVER;
        end else begin
          m_cur = m_pending; m_elapsed = 0; m_phase = M_PLAY;
          nn = after(m_cur, a, w);
          push(EV_START, cyc + 1, m_cur, nn, m_round, 0);
        end
      end
      default: ;
    endcase
  endtask

  // ---------------- monitor ----------------
  task automatic match(input ev_kind_t seen);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d with nothing expected (cycle %0d)", seen, cyc);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", seen, e.kind);
    check("event_cycle", cyc, e.cyc);
    if (seen != e.kind) return;
    case (e.kind)
      EV_START: begin
        check("start_current_player", current_player, e.player);
        check("start_next_player", next_player, e.nxt);
        check("start_round", round, e.round);
        check("start_turn_timer", turn_timer, T - 1);
      end
      EV_TIMEOUT: begin
        check("timeout_player", current_player, e.player);
        check("timeout_timer", turn_timer, 0);
      end
      EV_ROUND: if (e.round >= 0) check("round_end_round", round, e.round);
      EV_OVER: begin
        check("over_winner", winner, e.winner);
        check("over_current_player", current_player, 0);
        check("over_next_player", next_player, 0);
      end
      default: ;
    endcase
  endtask

  bit prev_go = 1'b0;
  always @(negedge clk_100M) begin
    if (reset_n) begin
      if (turn_start)             match(EV_START);
      if (round_end)              match(EV_ROUND);
      if (turn_timeout)           match(EV_TIMEOUT);
      if (game_over && !prev_go)  match(EV_OVER);
      prev_go = game_over;
    end else begin
      prev_go = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input bit st, input logic [N-1:0] a, input bit mv);
    start = st; alive = a; move_done = mv;
    model_step(st, a, mv);
    @(posedge clk_100M);
    #1;
  endtask

  task automatic check_all_zero();
    check("rst_current_player", current_player, 0);
    check("rst_next_player", next_player, 0);
    check("rst_round", round, 0);
    check("rst_turn_timer", turn_timer, 0);
    check("rst_turn_start", turn_start, 0);
    check("rst_turn_timeout", turn_timeout, 0);
    check("rst_round_end", round_end, 0);
    check("rst_game_over", game_over, 0);
    check("rst_winner", winner, 0);
  endtask

  // Asserted mid-cycle so the asynchronous clear is observed before any clock edge.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1 check_all_zero();
    exp_q.delete();
    m_phase = M_IDLE;
    start = 1'b0; move_done = 1'b0;
    @(posedge clk_100M);
    #1 reset_n = 1'b1;
  endtask

  task automatic run_scenario(input logic [N-1:0] mask, input int mode, input bit kill_en,
                              input int max_cycles, input bit force_reset);
    logic [N-1:0] a;
    bit mv, st;
    if (force_reset || m_phase != M_OVER) do_reset();
    a = mask;
    tick(1'b1, a, 1'b0);
    for (int k = 0; k < max_cycles && m_phase != M_OVER; k++) begin
      case (mode)
        1:       mv = ($urandom_range(0, 2) == 0);
        2:       mv = ($urandom_range(0, 7) == 0);
        default: mv = 1'b0;
      endcase
      if (m_phase == M_PLAY && m_elapsed == T - 1 && $urandom_range(0, 2) == 0) mv = 1'b1;
      if (kill_en && $urandom_range(0, 39) == 0) a[$urandom_range(0, N - 1)] = 1'b0;
      st = ($urandom_range(0, 49) == 0);
      tick(st, a, mv);
    end
    repeat (3) tick(1'b0, a, 1'b0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    #12 check_all_zero();
    @(posedge clk_100M);
    #1 reset_n = 1'b1;

    run_scenario(7'b0000111, 2, 1'b0, 1200, 1'b0);  // plain rotation
    run_scenario(7'b1010010, 1, 1'b0, 1200, 1'b0);  // dead players skipped
    run_scenario(7'b0000111, 0, 1'b0, 150,  1'b0);  // timeouts, cut off mid-turn
    run_scenario(7'b0000111, 1, 1'b1, 1200, 1'b0);  // restart after reset, eliminations
    run_scenario(7'b0000001, 1, 1'b0, 10,   1'b1);  // lone survivor
    run_scenario(7'b0000000, 1, 1'b0, 10,   1'b1);  // nobody alive
    run_scenario(7'b0000011, 1, 1'b0, 1200, 1'b0);  // round saturation draw
    for (int s = 0; s < 8; s++) begin
      logic [N-1:0] m;
      m = N'($urandom_range(0, (1 << N) - 1));
      run_scenario(m, $urandom_range(0, 2), 1'b1, (s == 3) ? 60 : 1200, $countones(m) <= 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
